// File: rtl/memory_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// memory_bus_arbiter_if
//   One request/response memory port. A requester drives read/write/addr/wdata
//   and receives rdata/response. Used for both master links and for the
//   memory link of memory_bus_arbiter.
//
//   read      requester -> responder  read request / strobe
//   write     requester -> responder  write request / strobe
//   addr      requester -> responder  address
//   wdata     requester -> responder  write data
//   rdata     responder -> requester  read data, valid with response
//   response  responder -> requester  transaction done
//
//   modport master : the requesting side
//   modport slave  : the responding side
// ----------------------------------------------------------------------------
interface memory_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  response;

    modport master (
        output read, write, addr, wdata,
        input  rdata, response
    );

    modport slave (
        input  read, write, addr, wdata,
        output rdata, response
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// ----------------------------------------------------------------------------
// memory_bus_arbiter
//   Shares one memory port between M0 (core control path) and M1 (loader/DMA).
//   One master owns the bus per transaction; ties are broken round-robin.
//   The owner's request is forwarded to memory and the memory response and
//   read data are routed back to the owner only. A watchdog forces a release
//   with timeout_err if memory never answers.
//
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   m0           slave  port of master 0 (read/write/addr/wdata in, rdata/response out)
//   m1           slave  port of master 1
//   mem          master port towards memory
//   owner        out  current / last granted master
//   busy         out  transaction in flight
//   timeout_err  out  1-cycle pulse on watchdog release
// ----------------------------------------------------------------------------
module memory_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    memory_bus_arbiter_if.slave  m0,
    memory_bus_arbiter_if.slave  m1,
    memory_bus_arbiter_if.master mem,
    output logic                 owner,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int              CW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  rr_last_q, rr_last_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

    logic                  req0, req1;
    logic                  sel_read, sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  expire, done;
    logic [DATA_WIDTH-1:0] resp_data;

    // Datapath: forward the owner's request, route the response back.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        req0      = m0.read | m0.write;
        req1      = m1.read | m1.write;

        sel_read  = owner_q ? m1.read  : m0.read;
        sel_write = owner_q ? m1.write : m0.write;
        sel_addr  = owner_q ? m1.addr  : m0.addr;
        sel_wdata = owner_q ? m1.wdata : m0.wdata;

        busy        = (state_q == BUSY);
        // A real response in the last watchdog cycle wins over the timeout.
        expire      = busy && !mem.response && (count_q == LAST_COUNT);
        done        = busy && (mem.response || expire);
        timeout_err = expire;
        owner       = owner_q;

        // Write has priority when the owner raises both strobes.
        mem.write = busy & sel_write;
        mem.read  = busy & sel_read & ~sel_write;
        mem.addr  = busy ? sel_addr  : '0;
        mem.wdata = busy ? sel_wdata : '0;

        resp_data   = expire ? '0 : mem.rdata;
        m0.response = done & ~owner_q;
        m1.response = done &  owner_q;
        m0.rdata    = m0.response ? resp_data : m0_rdata_q;
        m1.rdata    = m1.response ? resp_data : m1_rdata_q;
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        count_d   = count_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = BUSY;
                    // On a tie the master that did not finish last wins.
                    owner_d = (req0 && req1) ? ~rr_last_q : req1;
                    count_d = '0;
                end
            end
            BUSY: begin
                if (done) begin
                    state_d   = IDLE;
                    rr_last_d = owner_q;
                    count_d   = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    // NOTE: the held read-data registers are reset too, so masters see 0
    // rather than X until their first response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_last_q  <= 1'b1;
            count_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            count_q    <= count_d;
            m0_rdata_q <= m0.rdata;
            m1_rdata_q <= m1.rdata;
        end
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_memory_bus_arbiter
//   Directed scenarios plus a randomized run, all compared cycle by cycle
//   against a transaction-level reference model of the arbiter.
// ----------------------------------------------------------------------------
module tb_memory_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;

    typedef logic [5 + AW + DW + 2 * (1 + DW) - 1:0] vec_t;

    logic clk = 1'b0;
    logic reset;
    logic owner, busy, timeout_err;

    memory_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    memory_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    memory_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    memory_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0         (m0_if),
        .m1         (m1_if),
        .mem        (mem_if),
        .owner      (owner),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- reference model (transaction level) ----------------
    int      cur;          // master holding the bus, -1 when none
    int      age;          // cycles the current transaction has waited
    logic    last_win;     // master that completed most recently
    logic    own;          // last granted master
    logic [DW-1:0] held [2];

    logic    e_busy, e_tout, e_mr, e_mw, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic    e_resp [2];
    logic [DW-1:0] e_rdata [2];
    int      e_winner;

    function automatic void model_eval();
        logic rq0, rq1, rd, wr;
        rq0      = m0_if.read | m0_if.write;
        rq1      = m1_if.read | m1_if.write;
        e_busy   = (cur >= 0);
        e_tout   = 1'b0;
        e_done   = 1'b0;
        e_mr     = 1'b0;
        e_mw     = 1'b0;
        e_addr   = '0;
        e_wdata  = '0;
        e_resp[0] = 1'b0;
        e_resp[1] = 1'b0;
        e_rdata  = held;
        e_winner = -1;
        if (cur < 0) begin
            if (rq0 && rq1)  e_winner = 1 - int'(last_win);
            else if (rq0)    e_winner = 0;
            else if (rq1)    e_winner = 1;
        end else begin
            rd      = (cur == 0) ? m0_if.read  : m1_if.read;
            wr      = (cur == 0) ? m0_if.write : m1_if.write;
            e_addr  = (cur == 0) ? m0_if.addr  : m1_if.addr;
            e_wdata = (cur == 0) ? m0_if.wdata : m1_if.wdata;
            e_mw    = wr;
            e_mr    = rd && !wr;
            if (mem_if.response) begin
                e_done       = 1'b1;
                e_rdata[cur] = mem_if.rdata;
            end else if (age == T - 1) begin
                e_done       = 1'b1;
                e_tout       = 1'b1;
                e_rdata[cur] = '0;
            end
            e_resp[cur] = e_done;
        end
    endfunction

    function automatic void model_advance();
        if (reset) begin
            cur = -1; age = 0; last_win = 1'b1; own = 1'b0;
            held[0] = '0; held[1] = '0;
        end else begin
            held = e_rdata;
            if (cur < 0) begin
                if (e_winner >= 0) begin
                    cur = e_winner; own = (e_winner == 1); age = 0;
                end
            end else if (e_done) begin
                last_win = own; cur = -1; age = 0;
            end else begin
                age++;
            end
        end
    endfunction

    function automatic vec_t exp_vec();
        return {e_busy, own, e_tout, e_mr, e_mw, e_addr, e_wdata,
                e_resp[0], e_rdata[0], e_resp[1], e_rdata[1]};
    endfunction

    function automatic vec_t dut_vec();
        return {busy, owner, timeout_err, mem_if.read, mem_if.write, mem_if.addr, mem_if.wdata,
                m0_if.response, m0_if.rdata, m1_if.response, m1_if.rdata};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_m(int i, logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        if (i == 0) begin
            m0_if.read = r; m0_if.write = w; m0_if.addr = a; m0_if.wdata = d;
        end else begin
            m1_if.read = r; m1_if.write = w; m1_if.addr = a; m1_if.wdata = d;
        end
    endtask

    task automatic set_mem(logic resp, logic [DW-1:0] d);
        mem_if.response = resp;
        mem_if.rdata    = d;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_eval();
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        set_m(0, 0, 0, '0, '0);
        set_m(1, 0, 0, '0, '0);
        set_mem(1'b0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cur = -1; age = 0; last_win = 1'b1; own = 1'b0;
        held[0] = '0; held[1] = '0;
        do_reset();
        do_reset();
        sample();
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec()); fails++;
        end
        tests++;
        if (busy !== 1'b0 || owner !== 1'b0 || timeout_err !== 1'b0 || mem_if.read !== 1'b0 ||
            mem_if.write !== 1'b0 || mem_if.addr !== '0 || m0_if.rdata !== '0 || m1_if.rdata !== '0) begin
            $display("FAIL reset_values: busy=%b owner=%b to=%b rd=%b wr=%b addr=%h r0=%h r1=%h, expected all 0",
                     busy, owner, timeout_err, mem_if.read, mem_if.write, mem_if.addr, m0_if.rdata, m1_if.rdata);
            fails++;
        end
        tests++;
        tick();
    endtask

    task automatic test_single_read();
        for (int c = 0; c < 5; c++) begin
            set_m(0, c < 4, 1'b0, 32'h10, '0);
            set_m(1, 1'b0, 1'b0, '0, '0);
            set_mem(c == 3, (c == 3) ? 32'hDEADBEEF : $urandom());
            sample();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL single_read_vec cyc %0d: got %h expected %h", c, dut_vec(), exp_vec()); fails++;
            end
            tests++;
            if (c == 0) begin
                if (mem_if.read !== 1'b0 || busy !== 1'b0) begin
                    $display("FAIL single_read_idle: rd=%b busy=%b expected 0 0", mem_if.read, busy); fails++;
                end
                tests++;
            end else if (c <= 3) begin
                if (mem_if.read !== 1'b1 || mem_if.addr !== 32'h10) begin
                    $display("FAIL single_read_fwd cyc %0d: rd=%b addr=%h expected 1 00000010", c, mem_if.read, mem_if.addr); fails++;
                end
                tests++;
            end
            if (c == 3) begin
                if (m0_if.response !== 1'b1 || m0_if.rdata !== 32'hDEADBEEF || m1_if.response !== 1'b0) begin
                    $display("FAIL single_read_resp: r0=%b d0=%h r1=%b expected 1 deadbeef 0",
                             m0_if.response, m0_if.rdata, m1_if.response); fails++;
                end
                tests++;
            end
            if (c == 4) begin
                if (busy !== 1'b0 || m0_if.rdata !== 32'hDEADBEEF) begin
                    $display("FAIL single_read_hold: busy=%b d0=%h expected 0 deadbeef", busy, m0_if.rdata); fails++;
                end
                tests++;
            end
            tick();
        end
    endtask

    task automatic test_contention();
        logic active [2];
        int   g_owner [$];
        int   g_cyc [$];
        logic prev_busy = 1'b0;
        do_reset();
        active[0] = 1'b1; active[1] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            set_m(0, active[0], 1'b0, 32'h100, '0);
            set_m(1, active[1], 1'b0, 32'h200, '0);
            set_mem(cur >= 0 && age == 1, 32'h1000 + c);
            sample();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL contention_vec cyc %0d: got %h expected %h", c, dut_vec(), exp_vec()); fails++;
            end
            tests++;
            if (busy === 1'b1 && prev_busy !== 1'b1) begin
                g_owner.push_back(int'(owner)); g_cyc.push_back(c);
            end
            prev_busy = busy;
            if (e_resp[0]) active[0] = 1'b0;
            if (e_resp[1]) active[1] = 1'b0;
            tick();
        end
        if (g_owner.size() != 2 || g_owner[0] != 0 || g_cyc[0] != 1 || g_owner[1] != 1 || g_cyc[1] != 4) begin
            $display("FAIL contention_order: %0d grants, first owner %0d at %0d, expected M0@1 then M1@4",
                     g_owner.size(), (g_owner.size() > 0) ? g_owner[0] : -1, (g_cyc.size() > 0) ? g_cyc[0] : -1);
            fails++;
        end
        tests++;
    endtask

    task automatic test_fetch_alternate();
        logic m1_active = 1'b1;
        int   g_owner [$];
        logic prev_busy = 1'b0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            set_m(0, c < 6, 1'b0, 32'h40, '0);
            set_m(1, 1'b0, m1_active, 32'h20, 32'h55);
            set_mem(cur >= 0, 32'hA000 + c);
            sample();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL alternate_vec cyc %0d: got %h expected %h", c, dut_vec(), exp_vec()); fails++;
            end
            tests++;
            if (busy === 1'b1) begin
                if (mem_if.write !== owner ||
                    (owner === 1'b1 && (mem_if.wdata !== 32'h55 || mem_if.addr !== 32'h20)) ||
                    (owner === 1'b0 && (mem_if.read !== 1'b1 || mem_if.addr !== 32'h40))) begin
                    $display("FAIL alternate_fwd cyc %0d: owner=%b wr=%b rd=%b addr=%h wd=%h",
                             c, owner, mem_if.write, mem_if.read, mem_if.addr, mem_if.wdata); fails++;
                end
                tests++;
            end
            if (busy === 1'b1 && prev_busy !== 1'b1) g_owner.push_back(int'(owner));
            prev_busy = busy;
            if (e_resp[1]) m1_active = 1'b0;
            tick();
        end
        if (g_owner.size() != 3 || g_owner[0] != 0 || g_owner[1] != 1 || g_owner[2] != 0) begin
            $display("FAIL alternate_order: %0d grants, expected M0,M1,M0", g_owner.size()); fails++;
        end
        tests++;
    endtask

    task automatic test_timeout();
        for (int c = 0; c < 6; c++) begin
            set_m(0, c < 5, 1'b0, 32'h80, '0);
            set_m(1, 1'b0, 1'b0, '0, '0);
            set_mem(1'b0, 32'hFFFF_0000 | c);
            sample();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL timeout_vec cyc %0d: got %h expected %h", c, dut_vec(), exp_vec()); fails++;
            end
            tests++;
            if (timeout_err !== (c == 4) || m0_if.response !== (c == 4)) begin
                $display("FAIL timeout_pulse cyc %0d: to=%b r0=%b expected %0d %0d",
                         c, timeout_err, m0_if.response, c == 4, c == 4); fails++;
            end
            tests++;
            if ((c == 4 && m0_if.rdata !== '0) || (c == 5 && busy !== 1'b0)) begin
                $display("FAIL timeout_release cyc %0d: d0=%h busy=%b expected 0 0", c, m0_if.rdata, busy); fails++;
            end
            tests++;
            tick();
        end
    endtask

    task automatic test_reset_busy();
        logic act0 = 1'b0, act1 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            reset = (c == 1);
            if (c == 2) act0 = 1'b1;
            set_m(0, act0, 1'b0, 32'h5, '0);
            set_m(1, 1'b0, act1, 32'h99, 32'h1234);
            set_mem(c == 3 || c == 5, 32'hCAFE0000);
            sample();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL reset_busy_vec cyc %0d: got %h expected %h", c, dut_vec(), exp_vec()); fails++;
            end
            tests++;
            if (c == 2 && (busy !== 1'b0 || mem_if.write !== 1'b0 || mem_if.read !== 1'b0 ||
                           m0_if.response !== 1'b0 || m1_if.response !== 1'b0)) begin
                $display("FAIL reset_busy_drop: busy=%b wr=%b rd=%b r0=%b r1=%b expected all 0",
                         busy, mem_if.write, mem_if.read, m0_if.response, m1_if.response); fails++;
            end
            if (c == 3 && (busy !== 1'b1 || owner !== 1'b0)) begin
                $display("FAIL reset_busy_regrant: busy=%b owner=%b expected 1 0", busy, owner); fails++;
            end
            if (c == 2 || c == 3) tests++;
            if (e_resp[0]) act0 = 1'b0;
            if (e_resp[1]) act1 = 1'b0;
            tick();
        end
    endtask

    task automatic test_rw_conflict();
        for (int c = 0; c < 4; c++) begin
            set_m(0, c == 1 || c == 2, c == 1 || c == 2, 32'h30, 32'h77);
            set_m(1, 1'b0, 1'b0, '0, '0);
            set_mem(c == 0 || c == 2, (c == 0) ? 32'hBAD0BAD0 : 32'h0000_1111);
            sample();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL rw_conflict_vec cyc %0d: got %h expected %h", c, dut_vec(), exp_vec()); fails++;
            end
            tests++;
            if (c == 0 && (m0_if.response !== 1'b0 || m1_if.response !== 1'b0 || m0_if.rdata !== 32'hCAFE0000)) begin
                $display("FAIL idle_response_ignored: r0=%b r1=%b d0=%h expected 0 0 cafe0000",
                         m0_if.response, m1_if.response, m0_if.rdata); fails++;
            end
            if (c == 2 && (mem_if.write !== 1'b1 || mem_if.read !== 1'b0 || mem_if.wdata !== 32'h77)) begin
                $display("FAIL rw_write_wins: wr=%b rd=%b wd=%h expected 1 0 00000077",
                         mem_if.write, mem_if.read, mem_if.wdata); fails++;
            end
            if (c == 0 || c == 2) tests++;
            tick();
        end
    endtask

    task automatic test_random();
        logic act [2], r [2], w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; r[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && $urandom_range(0, 9) < 4) begin
                    act[i] = 1'b1;
                    r[i] = 1'($urandom_range(0, 1));
                    w[i] = 1'($urandom_range(0, 1));
                    if (!r[i] && !w[i]) r[i] = 1'b1;
                    a[i] = $urandom();
                    d[i] = $urandom();
                end
                set_m(i, act[i] & r[i], act[i] & w[i], a[i], d[i]);
            end
            set_mem($urandom_range(0, 9) < 3, $urandom());
            sample();
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL random_vec cyc %0d: got %h expected %h", c, dut_vec(), exp_vec()); fails++;
            end
            tests++;
            for (int i = 0; i < 2; i++) if (e_resp[i]) act[i] = 1'b0;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion before 200000");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        set_m(0, 0, 0, '0, '0);
        set_m(1, 0, 0, '0, '0);
        set_mem(1'b0, '0);
        #1;
        test_reset();
        test_single_read();
        test_contention();
        test_fetch_alternate();
        test_timeout();
        test_reset_busy();
        test_rw_conflict();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
